jtframe_sdram_stats_win: RTL and testbench

Synthesisable, windowed SDRAM command statistics monitor. It snoops the SDRAM command/address pins driven by the controller, accumulates per-bank activation and row-hit statistics plus global read/write/refresh counts over a measurement window, and snapshots them into readable report registers. It sits beside the SDRAM controller, on the same clock, and feeds the debug/OSD path through a select/read port.

---
 rtl/jtframe_sdram_stats_win.sv | 242 ++++++++++++++++++++++++
 tb/tb_jtframe_sdram_stats_win.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_sdram_stats_win.sv
// Windowed SDRAM command statistics monitor.
// Snoops the controller's command pins, keeps per-bank activation/row-hit
// statistics and global read/write/refresh counts over a measurement window,
// and latches them into report registers read through a select port.
module jtframe_sdram_stats_win #(
    parameter int BANKS   = 4,   // banks monitored (1..4)
    parameter int CW      = 16,  // counter and dout width
    parameter int WIN_CYC = 0    // window length in cycles, 0 = external win strobe
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [12:0]   sdram_a,
    input  logic [1:0]    sdram_ba,
    input  logic          sdram_ncs,
    input  logic          sdram_nras,
    input  logic          sdram_ncas,
    input  logic          sdram_nwe,
    input  logic          win,
    input  logic [3:0]    sel,
    output logic [CW-1:0] dout,
    output logic          rdy
);

    typedef logic [CW-1:0] cnt_t;

    // {ncs, nras, ncas, nwe}
    localparam logic [3:0] CMD_ACTIVE  = 4'b0011;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_WRITE   = 4'b0100;
    localparam logic [3:0] CMD_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_DESEL   = 4'b1111;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == {CW{1'b1}}) ? v : v + cnt_t'(1);
    endfunction

    // Registered pin stage
    logic [12:0] r_a;
    logic [1:0]  r_ba;
    logic [3:0]  r_cmd;

    // Per-bank live state
    cnt_t        r_act  [4];
    cnt_t        r_same [4];
    cnt_t        r_long [4];
    cnt_t        r_run  [4];
    logic [12:0] r_row  [4];
    logic [3:0]  r_row_valid;

    // Global live counters
    cnt_t r_rd, r_wr, r_ref;

    // Report registers
    cnt_t r_snap_act  [4];
    cnt_t r_snap_same [4];
    cnt_t r_snap_long [4];
    cnt_t r_snap_rd, r_snap_wr, r_snap_ref;
    cnt_t r_wnum;

    cnt_t r_dout;
    logic r_rdy;

    // Next-state values
    cnt_t        w_act_nxt  [4];
    cnt_t        w_same_nxt [4];
    cnt_t        w_long_nxt [4];
    cnt_t        w_run_nxt  [4];
    logic [12:0] w_row_nxt  [4];
    logic [3:0]  w_row_valid_nxt;
    cnt_t        w_rd_nxt, w_wr_nxt, w_ref_nxt;
    cnt_t        w_dout;
    logic        w_tick;
    logic        w_is_act;

    assign w_is_act = (r_cmd == CMD_ACTIVE);

    // Window tick source: free-running cycle counter or external strobe
    generate
        if (WIN_CYC > 0) begin : g_int_win
            localparam int WW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
            localparam logic [WW-1:0] LAST = WW'(WIN_CYC - 1);
            logic [WW-1:0] r_wcnt;
            logic          w_unused_win;

            assign w_unused_win = win;
            assign w_tick       = (r_wcnt == LAST);

            // Window cycle counter, wraps after the last cycle of the window
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wcnt <= '0;
                end else if (w_tick) begin
                    r_wcnt <= '0;
                end else begin
                    r_wcnt <= r_wcnt + WW'(1);
                end
            end
        end else begin : g_ext_win
            assign w_tick = win;
        end
    endgenerate

    // Register the command/address pins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_ba  <= '0;
            r_cmd <= CMD_DESEL;
        end else begin
            // NOTE: state is updated with <= so every register samples the
            // pre-edge values; blocking '=' here would create ordering races.
            r_a   <= sdram_a;
            r_ba  <= sdram_ba;
            r_cmd <= {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe};
        end
    end

    // Accumulator next values for the registered command
    always_comb begin
        // NOTE: every output gets a default before any condition, so no
        // path leaves a variable unassigned and no latch is inferred.
        w_rd_nxt        = (r_cmd == CMD_READ)    ? sat_inc(r_rd)  : r_rd;
        w_wr_nxt        = (r_cmd == CMD_WRITE)   ? sat_inc(r_wr)  : r_wr;
        w_ref_nxt       = (r_cmd == CMD_REFRESH) ? sat_inc(r_ref) : r_ref;
        w_row_valid_nxt = r_row_valid;
        for (int b = 0; b < 4; b++) begin
            w_act_nxt[b]  = r_act[b];
            w_same_nxt[b] = r_same[b];
            w_long_nxt[b] = r_long[b];
            w_run_nxt[b]  = r_run[b];
            w_row_nxt[b]  = r_row[b];
            if (b < BANKS && w_is_act && r_ba == 2'(b)) begin
                w_act_nxt[b] = sat_inc(r_act[b]);
                if (r_row_valid[b] && r_a == r_row[b]) begin
                    w_same_nxt[b] = sat_inc(r_same[b]);
                    w_run_nxt[b]  = sat_inc(r_run[b]);
                end else begin
                    w_run_nxt[b]       = cnt_t'(1);
                    w_row_nxt[b]       = r_a;
                    w_row_valid_nxt[b] = 1'b1;
                end
                // longest run uses the run length including this ACTIVE
                w_long_nxt[b] = (w_run_nxt[b] > r_long[b]) ? w_run_nxt[b] : r_long[b];
            end
        end
    end

    // Live counters, open-row tracking and window snapshots
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: these arrays are reset element by element because the
            // report must read zero after reset; they are flops, not RAM.
            for (int b = 0; b < 4; b++) begin
                r_act[b]       <= '0;
                r_same[b]      <= '0;
                r_long[b]      <= '0;
                r_run[b]       <= '0;
                r_row[b]       <= '0;
                r_snap_act[b]  <= '0;
                r_snap_same[b] <= '0;
                r_snap_long[b] <= '0;
            end
            r_row_valid <= '0;
            r_rd        <= '0;
            r_wr        <= '0;
            r_ref       <= '0;
            r_snap_rd   <= '0;
            r_snap_wr   <= '0;
            r_snap_ref  <= '0;
            r_wnum      <= '0;
        end else begin
            // open row and run length carry across window boundaries
            for (int b = 0; b < 4; b++) begin
                r_run[b] <= w_run_nxt[b];
                r_row[b] <= w_row_nxt[b];
            end
            r_row_valid <= w_row_valid_nxt;

            if (w_tick) begin
                // the event seen on the tick cycle belongs to the closing window
                for (int b = 0; b < 4; b++) begin
                    r_snap_act[b]  <= w_act_nxt[b];
                    r_snap_same[b] <= w_same_nxt[b];
                    r_snap_long[b] <= w_long_nxt[b];
                    r_act[b]       <= '0;
                    r_same[b]      <= '0;
                    r_long[b]      <= '0;
                end
                r_snap_rd  <= w_rd_nxt;
                r_snap_wr  <= w_wr_nxt;
                r_snap_ref <= w_ref_nxt;
                r_rd       <= '0;
                r_wr       <= '0;
                r_ref      <= '0;
                r_wnum     <= sat_inc(r_wnum);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    r_act[b]  <= w_act_nxt[b];
                    r_same[b] <= w_same_nxt[b];
                    r_long[b] <= w_long_nxt[b];
                end
                r_rd  <= w_rd_nxt;
                r_wr  <= w_wr_nxt;
                r_ref <= w_ref_nxt;
            end
        end
    end

    // Report select mux over snapshot registers only
    always_comb begin
        w_dout = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < BANKS) begin
                if (sel == 4'(3 * b))     w_dout = r_snap_act[b];
                if (sel == 4'(3 * b + 1)) w_dout = r_snap_same[b];
                if (sel == 4'(3 * b + 2)) w_dout = r_snap_long[b];
            end
        end
        case (sel)
            4'd12:   w_dout = r_snap_rd;
            4'd13:   w_dout = r_snap_wr;
            4'd14:   w_dout = r_snap_ref;
            4'd15:   w_dout = r_wnum;
            default: ;
        endcase
    end

    // Registered read port and snapshot-ready pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
            r_rdy  <= 1'b0;
        end else begin
            r_dout <= w_dout;
            r_rdy  <= w_tick;
        end
    end

    assign dout = r_dout;
    assign rdy  = r_rdy;

endmodule

// File: tb/tb_jtframe_sdram_stats_win.sv
// Bench for jtframe_sdram_stats_win: three instances (100-cycle window,
// 4-bit saturating counters, external window with two banks), directed
// traffic, and snapshot readout tables with hand-computed expectations.
module tb_jtframe_sdram_stats_win;

    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] RF  = 4'b0001;
    localparam logic [3:0] NOP = 4'b1111;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] a;
    logic [1:0]  ba;
    logic [3:0]  cmd;
    logic        win_ext;
    logic [3:0]  sel;

    logic [15:0] dout_dut;
    logic        rdy_dut;
    logic [3:0]  dout_sat;
    logic        rdy_sat;
    logic [15:0] dout_ext;
    logic        rdy_ext;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    jtframe_sdram_stats_win #(.BANKS(4), .CW(16), .WIN_CYC(100)) u_dut (
        .clk(clk), .rst(rst), .sdram_a(a), .sdram_ba(ba),
        .sdram_ncs(cmd[3]), .sdram_nras(cmd[2]), .sdram_ncas(cmd[1]), .sdram_nwe(cmd[0]),
        .win(win_ext), .sel(sel), .dout(dout_dut), .rdy(rdy_dut)
    );

    jtframe_sdram_stats_win #(.BANKS(4), .CW(4), .WIN_CYC(100)) u_sat (
        .clk(clk), .rst(rst), .sdram_a(a), .sdram_ba(ba),
        .sdram_ncs(cmd[3]), .sdram_nras(cmd[2]), .sdram_ncas(cmd[1]), .sdram_nwe(cmd[0]),
        .win(win_ext), .sel(sel), .dout(dout_sat), .rdy(rdy_sat)
    );

    jtframe_sdram_stats_win #(.BANKS(2), .CW(16), .WIN_CYC(0)) u_ext (
        .clk(clk), .rst(rst), .sdram_a(a), .sdram_ba(ba),
        .sdram_ncs(cmd[3]), .sdram_nras(cmd[2]), .sdram_ncas(cmd[1]), .sdram_nwe(cmd[0]),
        .win(win_ext), .sel(sel), .dout(dout_ext), .rdy(rdy_ext)
    );

    typedef struct {
        int          ph;   // readout phase
        int          dut;  // 0 = u_dut, 1 = u_sat, 2 = u_ext
        logic [3:0]  sel;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int ph, input int d, input int s, input int e);
        vec_t v;
        v.ph  = ph;
        v.dut = d;
        v.sel = 4'(s);
        v.exp = 16'(e);
        vecs.push_back(v);
    endfunction

    function automatic logic [15:0] dout_of(input int d);
        case (d)
            0:       return dout_dut;
            1:       return {12'b0, dout_sat};
            default: return dout_ext;
        endcase
    endfunction

    function automatic logic rdy_of(input int d);
        case (d)
            0:       return rdy_dut;
            1:       return rdy_sat;
            default: return rdy_ext;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // one command for one cycle, pins return to NOP afterwards
    task automatic cyc(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr);
        cmd = c;
        ba  = b;
        a   = addr;
        @(posedge clk); #1;
        cmd = NOP;
    endtask

    // bounded wait for a snapshot-ready pulse; returns the cycle it was seen
    task automatic wait_rdy(input int d, output int at);
        at = -1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (rdy_of(d)) begin
                at = tb_cyc;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL rdy timeout on instance %0d", d);
    endtask

    task automatic run_phase(input int ph);
        foreach (vecs[i]) begin
            if (vecs[i].ph == ph) begin
                sel = vecs[i].sel;
                @(posedge clk); #1;
                check($sformatf("ph%0d inst%0d sel%0d", ph, vecs[i].dut, vecs[i].sel),
                      32'(dout_of(vecs[i].dut)), 32'(vecs[i].exp));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, r2, r3, r4, r5, mark, early;

        // phase 1: empty window after reset
        for (int s = 0; s < 15; s++) add(1, 0, s, 0);
        add(1, 0, 15, 1);
        // phase 2: bank 1 rows 5,5,5,7,7 plus 10 RD, 4 WR, 2 REF
        for (int s = 0; s < 16; s++) begin
            case (s)
                3:       add(2, 0, s, 5);
                4:       add(2, 0, s, 3);
                5:       add(2, 0, s, 3);
                12:      add(2, 0, s, 10);
                13:      add(2, 0, s, 4);
                14:      add(2, 0, s, 2);
                15:      add(2, 0, s, 2);
                default: add(2, 0, s, 0);
            endcase
        end
        // phase 3: 20 ACTIVEs bank 0 same row, 16-bit and 4-bit counters
        add(3, 0, 0, 20); add(3, 0, 1, 19); add(3, 0, 2, 20); add(3, 0, 3, 0);
        add(3, 0, 15, 3);
        add(3, 1, 0, 15); add(3, 1, 1, 15); add(3, 1, 2, 15); add(3, 1, 12, 0);
        // phase 4: ACTIVE on the tick cycle lands in the closing window
        add(4, 0, 6, 1); add(4, 0, 7, 0); add(4, 0, 8, 1); add(4, 0, 0, 0);
        add(4, 0, 15, 4);
        // phase 5: same row right after the boundary continues the run
        add(5, 0, 6, 1); add(5, 0, 7, 1); add(5, 0, 8, 2); add(5, 0, 12, 0);
        add(5, 0, 15, 5);
        // phase 6: external window, one-cycle window holding a single WRITE
        add(6, 2, 0, 0); add(6, 2, 3, 0); add(6, 2, 4, 0); add(6, 2, 5, 0);
        for (int s = 6; s < 12; s++) add(6, 2, s, 0);
        add(6, 2, 12, 0); add(6, 2, 13, 1); add(6, 2, 14, 0); add(6, 2, 15, 2);
        // phase 7: banks 2/3 ignored with BANKS=2
        add(7, 2, 0, 1); add(7, 2, 1, 0); add(7, 2, 2, 1); add(7, 2, 3, 0);
        for (int s = 6; s < 12; s++) add(7, 2, s, 0);
        add(7, 2, 12, 0); add(7, 2, 13, 0); add(7, 2, 14, 1); add(7, 2, 15, 3);

        rst = 1'b1; cmd = NOP; a = '0; ba = '0; win_ext = 1'b0; sel = 4'd15;
        repeat (3) @(posedge clk);
        #1;
        check("reset dout", 32'(dout_dut), 0);
        check("reset rdy", 32'(rdy_dut), 0);
        check("reset dout ext", 32'(dout_ext), 0);
        check("reset rdy ext", 32'(rdy_ext), 0);

        // traffic, first window closes, then reset mid-traffic
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc((i % 2 == 0) ? ACT : RD, 2'd0, 13'(i));
        wait_rdy(0, r0);
        @(posedge clk); #1;
        check("pre-reset wnum", 32'(dout_dut), 1);
        cmd = ACT; ba = 2'd1; a = 13'd3;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid-traffic reset dout", 32'(dout_dut), 0);
        check("mid-traffic reset rdy", 32'(rdy_dut), 0);
        cmd = NOP;
        rst = 1'b0;
        mark = tb_cyc;

        // window 1: no commands
        wait_rdy(0, r1);
        check("first window length", 32'(r1 - mark), 100);
        @(posedge clk); #1;
        check("rdy single pulse w1", 32'(rdy_dut), 0);
        run_phase(1);

        // window 2: row hits and mixed commands
        cyc(ACT, 2'd1, 13'd5); cyc(ACT, 2'd1, 13'd5); cyc(ACT, 2'd1, 13'd5);
        cyc(ACT, 2'd1, 13'd7); cyc(ACT, 2'd1, 13'd7);
        repeat (10) cyc(RD, 2'd2, 13'd0);
        repeat (4)  cyc(WR, 2'd3, 13'd0);
        repeat (2)  cyc(RF, 2'd0, 13'd0);
        wait_rdy(0, r2);
        check("window 2 length", 32'(r2 - r1), 100);
        @(posedge clk); #1;
        check("rdy single pulse w2", 32'(rdy_dut), 0);
        run_phase(2);

        // window 3: saturation
        repeat (20) cyc(ACT, 2'd0, 13'd9);
        wait_rdy(0, r3);
        check("window 3 length", 32'(r3 - r2), 100);
        @(posedge clk); #1;
        check("rdy single pulse w3", 32'(rdy_dut), 0);
        run_phase(3);

        // window 4/5 boundary: ACTIVE registered on the tick cycle, then again
        while (tb_cyc < r3 + 98) begin
            @(posedge clk); #1;
        end
        cyc(ACT, 2'd2, 13'd3);
        check("no early rdy at boundary", 32'(rdy_dut), 0);
        cyc(ACT, 2'd2, 13'd3);
        check("boundary rdy", 32'(rdy_dut), 1);
        r4 = tb_cyc;
        @(posedge clk); #1;
        check("rdy single pulse w4", 32'(rdy_dut), 0);
        run_phase(4);
        wait_rdy(0, r5);
        check("window 5 length", 32'(r5 - r4), 100);
        run_phase(5);

        // external window instance, back-to-back win pulses
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ext reset dout", 32'(dout_ext), 0);
        sel   = 4'd12;
        rst   = 1'b0;
        early = 0;
        for (int i = 1; i <= 51; i++) begin
            case (i)
                1, 2: begin cmd = ACT; ba = 2'd1; a = 13'd4; end
                3:    begin cmd = ACT; ba = 2'd3; a = 13'd1; end
                4:    begin cmd = ACT; ba = 2'd2; a = 13'd1; end
                49:   begin cmd = RD;  ba = 2'd0; a = 13'd0; end
                50:   begin cmd = WR;  ba = 2'd0; a = 13'd0; end
                51:   begin cmd = RF;  ba = 2'd0; a = 13'd0; end
                default: cmd = NOP;
            endcase
            win_ext = (i == 50 || i == 51);
            @(posedge clk); #1;
            if (i < 50 && rdy_ext) early++;
            if (i == 50) check("ext rdy first pulse", 32'(rdy_ext), 1);
        end
        cmd = NOP;
        win_ext = 1'b0;
        check("ext rdy before win", 32'(early), 0);
        check("ext rdy second pulse", 32'(rdy_ext), 1);
        check("ext snapshot1 rd", 32'(dout_ext), 1);
        @(posedge clk); #1;
        check("ext rdy low after pair", 32'(rdy_ext), 0);
        run_phase(6);

        cyc(ACT, 2'd0, 13'd2);
        cyc(ACT, 2'd3, 13'd2);
        cyc(ACT, 2'd2, 13'd2);
        cyc(NOP, 2'd0, 13'd0);
        win_ext = 1'b1;
        @(posedge clk); #1;
        win_ext = 1'b0;
        check("ext rdy third pulse", 32'(rdy_ext), 1);
        run_phase(7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
